// File: rtl/spi_master_if.sv
// Host-side and SPI-wire signals of the mode-0 SPI master.
// Clock and reset stay outside as plain ports.
interface spi_master_if #(
    parameter int FRAME_BITS = 40
);
    logic                  start;
    logic [FRAME_BITS-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  spi_clk;
    logic                  spi_cs;
    logic                  spi_mosi;
    logic                  spi_miso;

    modport master (
        input  start, tx_data, spi_miso,
        output busy, done, rx_data, spi_clk, spi_cs, spi_mosi
    );

    modport slave (
        output start, tx_data, spi_miso,
        input  busy, done, rx_data, spi_clk, spi_cs, spi_mosi
    );
endinterface

// File: rtl/spi_master.sv
// Full-duplex SPI master, mode 0, MSB first, fixed frame length.
// Start/done pulse host interface; every output is registered.
module spi_master #(
    parameter int CLK_DIV    = 10,
    parameter int FRAME_BITS = 40,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_IDLE    = 2
) (
    input logic         clk,
    input logic         reset,
    spi_master_if.master bus
);
    localparam int M1 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int M2 = (M1 > CS_HOLD) ? M1 : CS_HOLD;
    localparam int MAXP = (M2 > CS_IDLE) ? M2 : CS_IDLE;
    localparam int PW = $clog2(MAXP + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int FB = FRAME_BITS;

    localparam logic [PW-1:0] DIV_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);
    localparam logic [PW-1:0] IDLE_LAST  = PW'(CS_IDLE - 1);
    localparam logic [BW-1:0] BITS       = BW'(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FB-1:0] tx_q, tx_d;
    logic [FB-1:0] rxsh_q, rxsh_d;
    logic [FB-1:0] rx_q, rx_d;
    logic          sclk_q, sclk_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PW'(1);
        bit_d   = bit_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (bus.start) begin
                    tx_d    = bus.tx_data;
                    mosi_d  = bus.tx_data[FB-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    phase_d = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_q == DIV_LAST) begin
                    phase_d = '0;
                    sclk_d  = 1'b1;
                    rxsh_d  = {rxsh_q[FB-2:0], bus.spi_miso};
                    bit_d   = bit_q + BW'(1);
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_q == DIV_LAST) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    if (bit_q < BITS) begin
                        // rotate so the next bit sits one below the MSB
                        tx_d    = {tx_q[FB-2:0], tx_q[FB-1]};
                        mosi_d  = tx_q[FB-2];
                        state_d = S_LOW;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    phase_d = '0;
                    cs_d    = 1'b1;
                    rx_d    = rxsh_q;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (phase_q == IDLE_LAST) begin
                    phase_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_q;
    assign bus.spi_clk  = sclk_q;
    assign bus.spi_cs   = cs_q;
    assign bus.spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a bit-level slave model drives miso,
// a monitor checks frame timing, MOSI stream and rx_data on every done.
module tb_spi_master;
    localparam int FB = 40;
    localparam int CD = 10;
    localparam int CSS = 2;
    localparam int CSH = 2;
    localparam int CSI = 2;
    localparam int CS_LOW = CSS + 2 * CD * FB + CSH;

    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_master_if #(.FRAME_BITS(FB)) bus ();

    spi_master #(
        .CLK_DIV(CD), .FRAME_BITS(FB), .CS_SETUP(CSS),
        .CS_HOLD(CSH), .CS_IDLE(CSI)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [FB-1:0] exp_rx_q[$];
    logic [FB-1:0] exp_tx_q[$];

    // slave model: 0 loopback, 1 all ones, 2 all zeros, 3 shift out resp
    int mode = 0;
    logic [FB-1:0] resp = '0;
    int nfall = 0;
    logic resp_bit;
    always_comb begin
        resp_bit = 1'b0;
        if (nfall < FB) resp_bit = resp[FB-1-nfall];
    end
    assign bus.spi_miso = (mode == 0) ? bus.spi_mosi :
                          (mode == 1) ? 1'b1 :
                          (mode == 2) ? 1'b0 : resp_bit;

    task automatic chk(input string name, input logic [FB-1:0] act,
                       input logic [FB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FB-1:0];
    endfunction

    // monitor
    logic pclk = 1'b0, pcs = 1'b1, pmosi = 1'b0;
    int cs_lo = 0, cs_hi = 0, rises = 0, mosi_hi = 0;
    logic [FB-1:0] cap = '0;
    logic gap_chk = 1'b0;
    logic skip = 1'b0;

    always @(negedge clk) begin
        if (pcs && !bus.spi_cs) begin
            if (gap_chk) chk("cs_gap", FB'(cs_hi), FB'(CSI + 1));
            cs_lo = 0;
            rises = 0;
            mosi_hi = 0;
            cap = '0;
            nfall = 0;
            skip = 1'b0;
        end
        if (!pcs && bus.spi_cs) begin
            if (!skip) chk("cs_low_len", FB'(cs_lo), FB'(CS_LOW));
            cs_hi = 0;
        end
        if (bus.spi_cs) cs_hi++;
        else cs_lo++;
        if (!bus.spi_cs && !pcs) begin
            if (!pclk && bus.spi_clk) begin
                rises++;
                cap = {cap[FB-2:0], bus.spi_mosi};
            end
            if (pclk && !bus.spi_clk) nfall++;
            if (bus.spi_clk && bus.spi_mosi !== pmosi) begin
                errors++;
                $display("FAIL mosi_stable: changed to %b with spi_clk high",
                         bus.spi_mosi);
            end
            if (bus.spi_mosi) mosi_hi++;
        end
        if (bus.spi_cs && pcs && bus.spi_clk !== pclk) begin
            errors++;
            $display("FAIL clk_idle: spi_clk moved to %b with cs high",
                     bus.spi_clk);
        end
        if (bus.done) begin
            if (exp_rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: rx %h, expected no done",
                         bus.rx_data);
            end else begin
                chk("rx_data", bus.rx_data, exp_rx_q.pop_front());
                chk("mosi_bits", cap, exp_tx_q.pop_front());
                chk("rise_count", FB'(rises), FB'(FB));
            end
        end
        pclk = bus.spi_clk;
        pcs = bus.spi_cs;
        pmosi = bus.spi_mosi;
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %b after %0d cycles, need 0",
                     bus.busy, n);
        end
    endtask

    task automatic start_frame(input logic [FB-1:0] w,
                               input logic [FB-1:0] e);
        wait_idle();
        exp_rx_q.push_back(e);
        exp_tx_q.push_back(w);
        bus.start = 1'b1;
        bus.tx_data = w;
        @(negedge clk);
        bus.start = 1'b0;
        bus.tx_data = rnd();
        chk("accept_busy", FB'(bus.busy), FB'(1));
        chk("accept_cs", FB'(bus.spi_cs), FB'(0));
        chk("accept_mosi", FB'(bus.spi_mosi), FB'(w[FB-1]));
    endtask

    initial begin
        logic [FB-1:0] w;
        logic [FB-1:0] ones;
        int nd;
        ones = '1;
        bus.start = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", FB'(bus.spi_cs), FB'(1));
        chk("rst_clk", FB'(bus.spi_clk), FB'(0));
        chk("rst_mosi", FB'(bus.spi_mosi), FB'(0));
        chk("rst_busy", FB'(bus.busy), FB'(0));
        chk("rst_done", FB'(bus.done), FB'(0));
        chk("rst_rx", bus.rx_data, '0);
        reset = 1'b0;
        @(negedge clk);

        mode = 0;
        start_frame(40'hA5_DEADBEEF, 40'hA5_DEADBEEF);
        wait_idle();

        mode = 1;
        start_frame('0, ones);
        wait_idle();
        chk("mosi_zero", FB'(mosi_hi), FB'(0));
        mode = 2;
        w = rnd();
        start_frame(w, '0);
        wait_idle();

        mode = 3;
        resp = 40'h00_00001234;
        start_frame(40'h01_00000000, 40'h00_00001234);
        wait_idle();

        mode = 0;
        w = rnd();
        start_frame(w, w);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.tx_data = ~w;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (394) @(negedge clk);
        bus.start = 1'b1;
        bus.tx_data = rnd();
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        w = rnd();
        start_frame(w, w);
        repeat (299) @(negedge clk);
        skip = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rx_q.delete();
        exp_tx_q.delete();
        chk("mid_rst_cs", FB'(bus.spi_cs), FB'(1));
        chk("mid_rst_clk", FB'(bus.spi_clk), FB'(0));
        chk("mid_rst_busy", FB'(bus.busy), FB'(0));
        chk("mid_rst_rx", bus.rx_data, '0);
        repeat (5) @(negedge clk);
        w = rnd();
        start_frame(w, w);
        wait_idle();

        w = rnd();
        for (int i = 0; i < 3; i++) begin
            exp_rx_q.push_back(w);
            exp_tx_q.push_back(w);
        end
        bus.start = 1'b1;
        bus.tx_data = w;
        nd = 0;
        for (int i = 0; i < 4000 && nd < 3; i++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                gap_chk = 1'b1;
                if (nd == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("held_dones", FB'(nd), FB'(3));
        wait_idle();
        gap_chk = 1'b0;

        for (int i = 0; i < 6; i++) begin
            w = rnd();
            resp = rnd();
            mode = ($urandom_range(1) == 0) ? 0 : 3;
            start_frame(w, (mode == 0) ? w : resp);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", FB'(exp_rx_q.size()), FB'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
